wall_query_arbiter: RTL

- Shares the single maze wall-lookup port between all movers: pacman plus four ghosts.
- Each mover posts probe coordinates, for example the sprite edge at X±Ball_Size.
- The arbiter issues one probe per clock to the lookup in round-robin order.
- It returns each wall/no-wall answer to the requester that asked, with a fixed pipeline latency.

---
 rtl/wall_query_arbiter_if.sv | 26 ++
 rtl/wall_query_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wall_query_arbiter_if.sv
// Wall-lookup sharing bus: requester side (Req/Ack/Is_Wall) plus the single lookup port.
// master: the movers and the maze lookup; slave: the arbiter.
interface wall_query_arbiter_if #(
   parameter int unsigned N_REQ   = 5,
   parameter int unsigned COORD_W = 10
);
   logic [N_REQ-1:0]         Req;
   logic [N_REQ*COORD_W-1:0] Req_X;
   logic [N_REQ*COORD_W-1:0] Req_Y;
   logic                     Lookup_Valid;
   logic [COORD_W-1:0]       Lookup_X;
   logic [COORD_W-1:0]       Lookup_Y;
   logic                     Lookup_Is_Wall;
   logic [N_REQ-1:0]         Ack;
   logic [N_REQ-1:0]         Is_Wall;

   modport master (
      output Req, Req_X, Req_Y, Lookup_Is_Wall,
      input  Lookup_Valid, Lookup_X, Lookup_Y, Ack, Is_Wall
   );

   modport slave (
      input  Req, Req_X, Req_Y, Lookup_Is_Wall,
      output Lookup_Valid, Lookup_X, Lookup_Y, Ack, Is_Wall
   );
endinterface

// File: rtl/wall_query_arbiter.sv
// Round-robin arbiter sharing one maze wall-lookup port among N_REQ movers
// (0 = pacman, 1..N_REQ-1 = ghosts). One probe issued per clock, answers returned
// to the asking mover after a fixed LAT-cycle lookup latency.
// Optional: define WALL_ARB_PACMAN_PRIORITY_EN to give requester 0 fixed priority.
module wall_query_arbiter #(
   parameter int unsigned N_REQ   = 5,
   parameter int unsigned LAT     = 1,
   parameter int unsigned COORD_W = 10
) (
   input logic               Clk,
   input logic               Reset,
   wall_query_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(N_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]   in_flight_q, in_flight_d;
   logic [N_REQ-1:0]   eligible;
   logic [N_REQ-1:0]   rot;
   logic [2*N_REQ-1:0] rot_dbl;
   logic [PTR_W-1:0]   offset;
   logic [PTR_W:0]     sum;
   logic [PTR_W-1:0]   winner;
   logic               grant_valid;
   logic               pri_win;
   logic [N_REQ-1:0]   grant;
   logic [COORD_W-1:0] sel_x, sel_y;
   logic               sel_oob;

   logic [N_REQ-1:0]   issue_tag_q;
   logic               issue_oob_q;
   logic [COORD_W-1:0] lookup_x_q, lookup_y_q;

   logic [N_REQ-1:0]   tag_pipe_q [LAT];
   logic               oob_pipe_q [LAT];
   logic [N_REQ-1:0]   ack;
   logic               ack_oob;
   logic [N_REQ-1:0]   is_wall_q;

   assign ack     = tag_pipe_q[LAT-1];
   assign ack_oob = oob_pipe_q[LAT-1];

   // A requester whose answer returns this cycle is free to be granted again.
   assign eligible = bus.Req & ~(in_flight_q & ~ack);

   // Rotate eligibility so bit 0 is the pointer position.
   assign rot_dbl = {eligible, eligible} >> ptr_q;
   assign rot     = rot_dbl[N_REQ-1:0];

`ifdef WALL_ARB_PACMAN_PRIORITY_EN
   assign pri_win = eligible[0];
`else
   assign pri_win = 1'b0;
`endif

   // Pick the first eligible requester at or after the pointer.
   always_comb begin
      grant_valid = 1'b0;
      offset      = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         if (!grant_valid && rot[k]) begin
            grant_valid = 1'b1;
            offset      = PTR_W'(k);
         end
      end
      sum = {1'b0, ptr_q} + {1'b0, offset};
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      winner = sum[PTR_W-1:0];
      if (pri_win) begin
         grant_valid = 1'b1;
         winner      = '0;
      end
   end

   // One-hot grant, winner's coordinates and out-of-screen detection.
   always_comb begin
      grant = '0;
      sel_x = '0;
      sel_y = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         if (grant_valid && (winner == PTR_W'(k))) begin
            grant[k] = 1'b1;
            sel_x    = bus.Req_X[k*COORD_W +: COORD_W];
            sel_y    = bus.Req_Y[k*COORD_W +: COORD_W];
         end
      end
      // Catches underflowed edges such as X - Ball_Size wrapping to ~1023.
      sel_oob = (32'(sel_x) >= 32'd640) || (32'(sel_y) >= 32'd480);
   end

   // Pointer advance and in-flight bookkeeping; a fixed-priority win keeps the pointer.
   always_comb begin
      ptr_d = ptr_q;
      if (grant_valid && !pri_win) begin
         ptr_d = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
      end
      in_flight_d = (in_flight_q & ~ack) | grant;
   end

   // Arbitration state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr_q       <= '0;
         in_flight_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         in_flight_q <= in_flight_d;
      end
   end

   // Issue stage: register the granted probe onto the lookup port.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         issue_tag_q <= '0;
         issue_oob_q <= 1'b0;
         lookup_x_q  <= '0;
         lookup_y_q  <= '0;
      end else begin
         issue_tag_q <= grant;
         issue_oob_q <= sel_oob;
         if (grant_valid) begin
            lookup_x_q <= sel_x;
            lookup_y_q <= sel_y;
         end
      end
   end

   // Tag pipeline matching the lookup latency.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(LAT); i++) begin
            tag_pipe_q[i] <= '0;
            oob_pipe_q[i] <= 1'b0;
         end
      end else begin
         tag_pipe_q[0] <= issue_tag_q;
         oob_pipe_q[0] <= issue_oob_q;
         for (int i = 1; i < int'(LAT); i++) begin
            tag_pipe_q[i] <= tag_pipe_q[i-1];
            oob_pipe_q[i] <= oob_pipe_q[i-1];
         end
      end
   end

   // Per-requester result capture; off-screen probes read as wall.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         is_wall_q <= '0;
      end else begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (ack[i]) begin
               is_wall_q[i] <= ack_oob | bus.Lookup_Is_Wall;
            end
         end
      end
   end

   assign bus.Lookup_Valid = (|issue_tag_q) & ~issue_oob_q;
   assign bus.Lookup_X     = lookup_x_q;
   assign bus.Lookup_Y     = lookup_y_q;
   assign bus.Ack          = ack;
   assign bus.Is_Wall      = is_wall_q;

endmodule
